// File: rtl/bias_memory_pkg.sv
// Shared constants and FSM state type for the bias memory reader.
package bias_memory_pkg;

  localparam int unsigned DefaultWidth     = 64;
  localparam int unsigned DefaultNumRows   = 32;
  localparam int unsigned DefaultBiasWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWake,
    StRead,
    StCapture,
    StStream,
    StFinish
  } state_e;

endpackage

// File: rtl/bias_row_unpacker.sv
// Holds one memory row and streams it out slice by slice over a valid/ready handshake.
module bias_row_unpacker #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned BIAS_WIDTH = 16,
  parameter int unsigned SLICES     = WIDTH / BIAS_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic [WIDTH-1:0]      row_i,
  input  logic                  last_row_i,
  input  logic                  bias_ready_i,
  output logic [BIAS_WIDTH-1:0] bias_o,
  output logic                  bias_valid_o,
  output logic                  bias_last_o,
  output logic                  row_done_o
);

  localparam int unsigned SliceW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [SliceW-1:0] LastSlice = SliceW'(SLICES - 1);

  logic [WIDTH-1:0]  row_q;
  logic [SliceW-1:0] slice_q;
  logic              valid_q;
  logic              last_row_q;
  logic              fire;
  logic              at_last_slice;

  assign fire          = valid_q && bias_ready_i;
  assign at_last_slice = (slice_q == LastSlice);

  // Flush beats load beats handshake; valid drops after the final slice is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q      <= '0;
      slice_q    <= '0;
      valid_q    <= 1'b0;
      last_row_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      slice_q <= '0;
    end else if (load_i) begin
      row_q      <= row_i;
      slice_q    <= '0;
      valid_q    <= 1'b1;
      last_row_q <= last_row_i;
    end else if (fire) begin
      if (at_last_slice) begin
        valid_q <= 1'b0;
        slice_q <= '0;
      end else begin
        slice_q <= slice_q + 1'b1;
      end
    end
  end

  assign bias_o       = row_q[slice_q * BIAS_WIDTH +: BIAS_WIDTH];
  assign bias_valid_o = valid_q;
  assign bias_last_o  = valid_q && last_row_q && at_last_slice;
  assign row_done_o   = fire && at_last_slice && !flush_i;

endmodule

// File: rtl/bias_memory_reader.sv
// Burst reader: wakes the bias memory, reads consecutive rows and streams their biases.
module bias_memory_reader
  import bias_memory_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned NUM_ROWS   = DefaultNumRows,
  parameter int unsigned BIAS_WIDTH = DefaultBiasWidth
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(NUM_ROWS)-1:0]  start_address,
  input  logic [$clog2(NUM_ROWS):0]    row_count,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_ROWS)-1:0]  mem_address,
  output logic                         mem_chip_select,
  output logic                         mem_write_enable,
  output logic                         mem_power_down,
  input  logic [WIDTH-1:0]             mem_data_out,
  output logic [BIAS_WIDTH-1:0]        bias_out,
  output logic                         bias_valid,
  input  logic                         bias_ready,
  output logic                         bias_last
);

  localparam int unsigned SLICES        = WIDTH / BIAS_WIDTH;
  localparam int unsigned ADDRESS_WIDTH = $clog2(NUM_ROWS);
  localparam logic [ADDRESS_WIDTH-1:0] LastRow = ADDRESS_WIDTH'(NUM_ROWS - 1);
  localparam logic [ADDRESS_WIDTH:0]   OneRow  = (ADDRESS_WIDTH + 1)'(1);

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [ADDRESS_WIDTH:0]   rows_left_q;
  logic                     chip_select_q;
  logic                     power_down_q;
  logic                     done_q;
  logic                     aborting;
  logic                     row_done;
  logic [ADDRESS_WIDTH-1:0] next_address;

  assign aborting     = abort && (state_q != StIdle);
  assign next_address = (address_q == LastRow) ? '0 : address_q + 1'b1;

  // Burst sequencer with registered memory controls and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      address_q     <= '0;
      rows_left_q   <= '0;
      chip_select_q <= 1'b0;
      power_down_q  <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      chip_select_q <= 1'b0;
      if (aborting) begin
        state_q      <= StIdle;
        power_down_q <= 1'b1;
        rows_left_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            power_down_q <= 1'b1;
            if (start) begin
              address_q   <= start_address;
              rows_left_q <= row_count;
              if (row_count == '0) begin
                state_q <= StFinish;
                done_q  <= 1'b1;
              end else begin
                state_q      <= StWake;
                power_down_q <= 1'b0;
              end
            end
          end
          StWake: begin
            state_q       <= StRead;
            chip_select_q <= 1'b1;
          end
          StRead:    state_q <= StCapture;
          StCapture: state_q <= StStream;
          StStream: begin
            if (row_done) begin
              if (rows_left_q == OneRow) begin
                state_q     <= StFinish;
                done_q      <= 1'b1;
                rows_left_q <= '0;
              end else begin
                state_q       <= StRead;
                chip_select_q <= 1'b1;
                address_q     <= next_address;
                rows_left_q   <= rows_left_q - 1'b1;
              end
            end
          end
          StFinish: begin
            state_q      <= StIdle;
            power_down_q <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  bias_row_unpacker #(
    .WIDTH      (WIDTH),
    .BIAS_WIDTH (BIAS_WIDTH),
    .SLICES     (SLICES)
  ) u_unpacker (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (state_q == StCapture),
    .flush_i      (aborting),
    .row_i        (mem_data_out),
    .last_row_i   (rows_left_q == OneRow),
    .bias_ready_i (bias_ready),
    .bias_o       (bias_out),
    .bias_valid_o (bias_valid),
    .bias_last_o  (bias_last),
    .row_done_o   (row_done)
  );

  assign busy             = (state_q != StIdle);
  assign done             = done_q;
  assign mem_address      = address_q;
  assign mem_chip_select  = chip_select_q;
  assign mem_write_enable = 1'b0;
  assign mem_power_down   = power_down_q;

endmodule

// File: tb/tb_bias_memory_reader.sv
// Scoreboard bench for bias_memory_reader with a synchronous-read memory model.
module tb_bias_memory_reader;

  localparam int W  = 64;
  localparam int NR = 32;
  localparam int BW = 16;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_address;
  logic [AW:0]   row_count;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address;
  logic          mem_chip_select;
  logic          mem_write_enable;
  logic          mem_power_down;
  logic [W-1:0]  mem_data_out;
  logic [BW-1:0] bias_out;
  logic          bias_valid;
  logic          bias_ready;
  logic          bias_last;

  bias_memory_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .start_address    (start_address),
    .row_count        (row_count),
    .abort            (abort),
    .busy             (busy),
    .done             (done),
    .mem_address      (mem_address),
    .mem_chip_select  (mem_chip_select),
    .mem_write_enable (mem_write_enable),
    .mem_power_down   (mem_power_down),
    .mem_data_out     (mem_data_out),
    .bias_out         (bias_out),
    .bias_valid       (bias_valid),
    .bias_ready       (bias_ready),
    .bias_last        (bias_last)
  );

  logic [W-1:0] mem [NR];
  logic [BW:0]  exp_q [$];
  int           exp_addr [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int cs_count = 0, valid_count = 0, done_count = 0, pop_count = 0;
  int last_pending = 0, last_cyc = 0;
  int rand_ready = 0;
  int stall_at = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: data appears the cycle after a chip-select cycle.
  always @(posedge clk) begin
    if (mem_chip_select) mem_data_out <= mem[mem_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sole driver of bias_ready: hold high, randomise, or stall 5 cycles at a chosen pop count.
  initial begin
    int stall_cnt = 0;
    int last_stall = -1;
    bias_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_at >= 0 && pop_count == stall_at && last_stall != stall_at) begin
        last_stall = stall_at;
        stall_cnt  = 5;
      end
      if (stall_cnt > 0) begin
        bias_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready != 0) begin
        bias_ready = 1'($urandom_range(0, 1));
      end else begin
        bias_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expectations on every accepted bias and every memory read.
  initial begin
    logic          prev_stall = 1'b0;
    logic          prev_abort = 1'b0;
    logic [BW-1:0] prev_val = '0;
    logic [BW:0]   e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check("write_enable", 64'(mem_write_enable), 64'd0);
        if (mem_chip_select) begin
          cs_count++;
          if (exp_addr.size() == 0) check("unexpected_read", 64'd1, 64'd0);
          else check("mem_address", 64'(mem_address), 64'(exp_addr.pop_front()));
        end
        if (bias_valid) valid_count++;
        if (prev_stall && !prev_abort) begin
          check("stall_valid", 64'(bias_valid), 64'd1);
          check("stall_bias", 64'(bias_out), 64'(prev_val));
        end
        if (bias_valid && bias_ready && !abort) begin
          pop_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_bias", 64'(bias_out), 64'hdead);
          end else begin
            e = exp_q.pop_front();
            check("bias_last_and_value", 64'({bias_last, bias_out}), 64'(e));
            if (e[BW]) begin
              last_pending = 1;
              last_cyc     = cyc;
            end
          end
        end
        if (done) begin
          done_count++;
          if (last_pending != 0) begin
            check("done_after_last", 64'(cyc), 64'(last_cyc + 1));
            last_pending = 0;
          end
        end
        prev_stall = bias_valid && !bias_ready;
        prev_val   = bias_out;
        prev_abort = abort;
      end
    end
  end

  // Reference model: rows wrap modulo NR, slices go out least-significant first.
  task automatic issue_start(input int sa, input int rc);
    @(posedge clk);
    #1;
    for (int r = 0; r < rc; r++) begin
      int row;
      logic [W-1:0] d;
      row = (sa + r) % NR;
      d   = mem[row];
      exp_addr.push_back(row);
      for (int k = 0; k < W / BW; k++) begin
        exp_q.push_back({(r == rc - 1) && (k == W / BW - 1), d[k*BW +: BW]});
      end
    end
    start         = 1'b1;
    start_address = AW'(sa);
    row_count     = (AW + 1)'(rc);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_burst(input string name, input int sa, input int rc);
    int d0, c0, t;
    d0 = done_count;
    c0 = cs_count;
    issue_start(sa, rc);
    t = 0;
    while (done_count == d0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({name, "_done_seen"}, 64'(done_count - d0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_done_single"}, 64'(done_count - d0), 64'd1);
    check({name, "_reads"}, 64'(cs_count - c0), 64'(rc));
    check({name, "_bias_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'({busy, mem_power_down}), 64'b01);
  endtask

  task automatic wait_pops(input int target);
    int t = 0;
    while (pop_count < target && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("pop_wait", 64'(pop_count >= target), 64'd1);
  endtask

  initial begin
    int d0, c0, v0, base;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start_address = '0;
    row_count = '0;
    for (int i = 0; i < NR; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    #12;
    check("reset_outputs",
          64'({busy, done, bias_valid, bias_last, bias_out, mem_address, mem_chip_select,
               mem_write_enable, mem_power_down}), 64'd1);
    rst_n = 1'b1;

    // Two rows from address 0, always ready.
    run_burst("basic", 0, 2);
    // Wrap from the last row.
    run_burst("wrap", 31, 2);
    // Back-pressure for 5 cycles on slice 2.
    stall_at = pop_count + 2;
    run_burst("stall", 2, 1);
    stall_at = -1;

    // Zero-length burst.
    c0 = cs_count;
    v0 = valid_count;
    run_burst("zero", 5, 0);
    check("zero_no_valid", 64'(valid_count - v0), 64'd0);
    check("zero_no_reads", 64'(cs_count - c0), 64'd0);

    // Abort while streaming row 1 of 3.
    d0 = done_count;
    base = pop_count;
    issue_start(4, 3);
    wait_pops(base + 5);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    exp_addr.delete();
    last_pending = 0;
    @(negedge clk);
    check("abort_state", 64'({busy, bias_valid, mem_chip_select, mem_power_down}), 64'b0001);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_count - d0), 64'd0);
    run_burst("after_abort", 10, 1);

    // Reset mid-stream.
    d0 = done_count;
    base = pop_count;
    issue_start(0, 2);
    wait_pops(base + 2);
    rst_n = 1'b0;
    #1;
    check("rst_outputs",
          64'({busy, done, bias_valid, bias_last, bias_out, mem_address, mem_chip_select,
               mem_write_enable, mem_power_down}), 64'd1);
    exp_q.delete();
    exp_addr.delete();
    last_pending = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = valid_count;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_count - d0), 64'd0);
    check("rst_no_valid", 64'(valid_count - v0), 64'd0);

    // Randomised bursts with random back-pressure.
    rand_ready = 1;
    for (int n = 0; n < 8; n++) begin
      run_burst("random", int'($urandom_range(0, NR - 1)), int'($urandom_range(1, 5)));
    end
    rand_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
